// File: rtl/vga_fb_pkg.sv
// Shared geometry, widths and fetch-state encoding for the VGA framebuffer arbiter.
package vga_fb_pkg;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int ADDR_W   = 19;
    localparam int DATA_W   = 16;
    localparam int LB_W     = $clog2(H_ACTIVE);
    localparam int LINE_W   = $clog2(V_ACTIVE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;
endpackage

// File: rtl/vga_rd_pipe.sv
// Tracks in-flight display reads: a DEPTH-stage {valid, index} shift register.
module vga_rd_pipe
    import vga_fb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int IDX_W = LB_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx
);
    logic [DEPTH-1:0] valid_sr;
    logic [IDX_W-1:0] idx_sr [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_sr <= '0;
            for (int i = 0; i < DEPTH; i++) idx_sr[i] <= '0;
        end else begin
            valid_sr[0] <= in_valid;
            idx_sr[0]   <= in_idx;
            for (int i = 1; i < DEPTH; i++) begin
                valid_sr[i] <= valid_sr[i-1];
                idx_sr[i]   <= idx_sr[i-1];
            end
        end
    end

    assign out_valid = valid_sr[DEPTH-1];
    assign out_idx   = idx_sr[DEPTH-1];
endmodule

// File: rtl/vga_fb_arbiter.sv
// Framebuffer port arbiter: display line prefetch has priority, host writes get
// a guaranteed slot every HOST_EVERY reads and own the memory otherwise.
module vga_fb_arbiter
    import vga_fb_pkg::*;
#(
    parameter logic [ADDR_W-1:0] FB_BASE    = '0,
    parameter int                RD_LAT     = 2,
    parameter int                HOST_EVERY = 8
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              line_req,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              lb_we,
    output logic [LB_W-1:0]   lb_addr,
    output logic [DATA_W-1:0] lb_data,
    output logic              busy,
    output logic              underrun
);
    localparam int                CNT_W     = $clog2(HOST_EVERY + 1);
    localparam logic [LB_W-1:0]   LAST_X    = LB_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0]  SLOT_AT   = CNT_W'(HOST_EVERY);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE);
    localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(V_ACTIVE - 1);

    fetch_state_e      state, state_next;
    logic [ADDR_W-1:0] line_ptr, line_base, base_now;
    logic [LINE_W-1:0] line_cnt, cnt_now;
    logic [LB_W-1:0]   x;
    logic [CNT_W-1:0]  slot_cnt;
    logic              slot, rd_issue, host_fire, req_accept;
    logic              iss_valid, pipe_valid;
    logic [LB_W-1:0]   iss_idx, pipe_idx;

    always_comb begin
        state_next = state;
        slot       = 1'b0;
        rd_issue   = 1'b0;
        case (state)
            IDLE:    if (line_req) state_next = FETCH;
            FETCH: begin
                slot     = (slot_cnt == SLOT_AT) && host_valid;
                rd_issue = !slot;
                if (rd_issue && x == LAST_X) state_next = DRAIN;
            end
            // Leave once the final read's data is being written to the line buffer.
            DRAIN:   if (pipe_valid && pipe_idx == LAST_X) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign host_ready = !reset && (state != FETCH || slot);
    assign host_fire  = host_valid && host_ready;
    assign req_accept = line_req && state == IDLE;
    assign busy       = state != IDLE;
    assign base_now   = frame_start ? FB_BASE : line_ptr;
    assign cnt_now    = frame_start ? '0 : line_cnt;

    always_ff @(posedge pclk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // frame_start takes effect before a same-cycle line_req; rejected requests still advance.
    always_ff @(posedge pclk) begin
        if (reset) begin
            line_ptr  <= FB_BASE;
            line_cnt  <= '0;
            line_base <= FB_BASE;
            underrun  <= 1'b0;
        end else begin
            underrun <= line_req && busy;
            if (line_req) begin
                if (cnt_now == LAST_LINE) begin
                    line_ptr <= FB_BASE;
                    line_cnt <= '0;
                end else begin
                    line_ptr <= base_now + LINE_STEP;
                    line_cnt <= cnt_now + 1'b1;
                end
            end else if (frame_start) begin
                line_ptr <= FB_BASE;
                line_cnt <= '0;
            end
            if (req_accept) line_base <= base_now;
        end
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            x        <= '0;
            slot_cnt <= '0;
        end else if (req_accept) begin
            x        <= '0;
            slot_cnt <= '0;
        end else if (rd_issue) begin
            x        <= x + 1'b1;
            slot_cnt <= (slot_cnt == SLOT_AT) ? slot_cnt : slot_cnt + 1'b1;
        end else if (slot) begin
            slot_cnt <= '0;
        end
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            iss_valid <= 1'b0;
            iss_idx   <= '0;
        end else begin
            mem_we    <= host_fire;
            iss_valid <= rd_issue;
            iss_idx   <= x;
            if (host_fire) begin
                mem_addr  <= host_addr;
                mem_wdata <= host_data;
            end else if (rd_issue) begin
                mem_addr <= line_base + ADDR_W'(x);
            end
        end
    end

    vga_rd_pipe #(
        .DEPTH (RD_LAT),
        .IDX_W (LB_W)
    ) u_rd_pipe (
        .clk       (pclk),
        .reset     (reset),
        .in_valid  (iss_valid),
        .in_idx    (iss_idx),
        .out_valid (pipe_valid),
        .out_idx   (pipe_idx)
    );

    always_ff @(posedge pclk) begin
        if (reset) begin
            lb_we   <= 1'b0;
            lb_addr <= '0;
            lb_data <= '0;
        end else begin
            lb_we <= pipe_valid;
            if (pipe_valid) begin
                lb_addr <= pipe_idx;
                lb_data <= mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter: directed fetch table, hand sequences and
// randomized traffic scored against a cycle-scheduled behavioural model.
module tb_vga_fb_arbiter;
    localparam int H       = 640;
    localparam int V       = 480;
    localparam int RD_LAT  = 2;
    localparam int HE      = 8;
    localparam logic [18:0] FB = 19'd0;

    logic        pclk = 1'b0;
    logic        reset, frame_start, line_req, host_valid, host_ready;
    logic [18:0] host_addr, mem_addr;
    logic [15:0] host_data, mem_wdata, mem_rdata, lb_data;
    logic        mem_we, lb_we, busy, underrun;
    logic [9:0]  lb_addr;

    int n_checks = 0;
    int n_errors = 0;
    int host_mode = 0;
    bit mon_en = 1'b0;
    int cyc = 0;

    vga_fb_arbiter #(.FB_BASE(FB), .RD_LAT(RD_LAT), .HOST_EVERY(HE)) dut (
        .pclk(pclk), .reset(reset), .frame_start(frame_start), .line_req(line_req),
        .host_valid(host_valid), .host_ready(host_ready), .host_addr(host_addr),
        .host_data(host_data), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .lb_we(lb_we), .lb_addr(lb_addr), .lb_data(lb_data),
        .busy(busy), .underrun(underrun)
    );

    always #5 pclk = ~pclk;

    function automatic logic [15:0] pix(input logic [18:0] a);
        return a[15:0] ^ {a[18:16], 13'h0A5C};
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected outputs scheduled by cycle into a small ring.
    typedef struct {
        logic        we;
        logic [18:0] addr;
        logic [15:0] data;
        logic        rd;
        logic [18:0] rd_addr;
        logic        lbw;
        logic [9:0]  lba;
        logic [15:0] lbd;
        logic        und;
    } exp_t;
    exp_t ring [16];

    logic [18:0] ahist [RD_LAT+1];
    bit          m_active;
    int          m_x, m_since, m_drain_end, m_cnt;
    logic [18:0] m_ptr, m_base;

    always @(negedge pclk) begin
        exp_t e;
        bit busy_exp, ready_exp, hs;
        logic [18:0] bnow;
        int cnow, k;
        cyc++;
        for (int i = RD_LAT; i > 0; i--) ahist[i] = ahist[i-1];
        ahist[0]  = mem_addr;
        mem_rdata = pix(ahist[RD_LAT]);

        e         = ring[cyc % 16];
        busy_exp  = m_active || (cyc < m_drain_end);
        ready_exp = !reset && (!m_active || (m_since == HE && host_valid));
        if (mon_en) begin
            check_output("host_ready", 32'(host_ready), 32'(ready_exp));
            check_output("busy", 32'(busy), 32'(busy_exp));
            check_output("mem_we", 32'(mem_we), 32'(e.we));
            if (e.we) begin
                check_output("wr_addr", 32'(mem_addr), 32'(e.addr));
                check_output("wr_data", 32'(mem_wdata), 32'(e.data));
            end
            if (e.rd) check_output("rd_addr", 32'(mem_addr), 32'(e.rd_addr));
            check_output("lb_we", 32'(lb_we), 32'(e.lbw));
            if (e.lbw) begin
                check_output("lb_addr", 32'(lb_addr), 32'(e.lba));
                check_output("lb_data", 32'(lb_data), 32'(e.lbd));
            end
            check_output("underrun", 32'(underrun), 32'(e.und));
        end
        ring[cyc % 16] = '{default: '0};

        if (reset) begin
            for (int i = 0; i < 16; i++) ring[i] = '{default: '0};
            m_active = 0; m_x = 0; m_since = 0; m_drain_end = 0;
            m_ptr = FB; m_cnt = 0; m_base = FB;
        end else begin
            hs = host_valid && ready_exp;
            if (hs) begin
                k = (cyc + 1) % 16;
                ring[k].we = 1'b1; ring[k].addr = host_addr; ring[k].data = host_data;
            end
            if (m_active) begin
                if (m_since == HE && host_valid) begin
                    m_since = 0;
                end else begin
                    k = (cyc + 1) % 16;
                    ring[k].rd = 1'b1; ring[k].rd_addr = 19'(m_base + 19'(m_x));
                    k = (cyc + RD_LAT + 2) % 16;
                    ring[k].lbw = 1'b1; ring[k].lba = 10'(m_x);
                    ring[k].lbd = pix(19'(m_base + 19'(m_x)));
                    m_x++;
                    if (m_since < HE) m_since++;
                    if (m_x == H) begin
                        m_active    = 0;
                        m_drain_end = cyc + RD_LAT + 2;
                    end
                end
            end
            if (line_req) begin
                bnow = frame_start ? FB : m_ptr;
                cnow = frame_start ? 0 : m_cnt;
                if (busy_exp) ring[(cyc + 1) % 16].und = 1'b1;
                else begin
                    m_active = 1; m_x = 0; m_since = 0; m_base = bnow;
                end
                if (cnow == V - 1) begin m_ptr = FB; m_cnt = 0; end
                else begin m_ptr = 19'(bnow + 19'(H)); m_cnt = cnow + 1; end
            end else if (frame_start) begin
                m_ptr = FB; m_cnt = 0;
            end
        end
    end

    task automatic drive_cycle(input logic fs, lr, rst, hv, input logic [18:0] ha, input logic [15:0] hd);
        frame_start = fs; line_req = lr; reset = rst;
        host_valid = hv; host_addr = ha; host_data = hd;
        @(posedge pclk);
        #2;
    endtask

    task automatic apply_stimulus(input logic fs, lr, rst);
        logic hv;
        hv = (host_mode == 1) ? 1'b1 : (host_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        drive_cycle(fs, lr, rst, hv, 19'($urandom), 16'($urandom));
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (busy && n < bound) begin apply_stimulus(0, 0, 0); n++; end
        check_output("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic run_fetch(input logic fs, input int extra_at,
                             output int base, output int busy_cnt, output int writes,
                             output int unds, output logic first_we);
        int i;
        apply_stimulus(fs, 1, 0);
        busy_cnt = int'(busy);
        writes = 0; unds = 0;
        apply_stimulus(0, 0, 0);
        base = int'(mem_addr); first_we = mem_we;
        i = 0;
        while (i < 2000) begin
            busy_cnt += int'(busy);
            if (i < 720) writes += int'(mem_we);
            unds += int'(underrun);
            if (!busy && i >= 720) break;
            apply_stimulus(0, 1'(i == extra_at), 0);
            i++;
        end
        if (i >= 2000) check_output("fetch_timeout", 32'(i), 32'd0);
    endtask

    typedef struct {
        logic fs;
        int   host;
        int   extra_at;
        int   exp_base;
        int   exp_busy;
        int   exp_writes;
        int   exp_und;
    } fetch_vec_t;
    fetch_vec_t vecs [7];

    initial begin
        int base, bcnt, wr, und, cnt;
        logic fwe;
        vecs[0] = '{1'b1, 0, -1,    0, 643,  0, 0};
        vecs[1] = '{1'b0, 0, -1,  640, 643,  0, 0};
        vecs[2] = '{1'b0, 1, -1, 1280, 722, 80, 0};
        vecs[3] = '{1'b0, 0, 100, 1920, 643, 0, 1};
        vecs[4] = '{1'b0, 0, -1, 3200, 643,  0, 0};
        vecs[5] = '{1'b1, 1, -1,    0, 722, 80, 0};
        vecs[6] = '{1'b0, 2, -1,  640,  -1, -1, 0};

        reset = 1'b1; frame_start = 0; line_req = 0; host_valid = 0;
        host_addr = '0; host_data = '0;
        drive_cycle(0, 0, 1, 0, '0, '0);
        drive_cycle(0, 0, 1, 0, '0, '0);
        mon_en = 1'b1;
        drive_cycle(0, 0, 1, 0, '0, '0);
        check_output("rst_busy", 32'(busy), 0);
        check_output("rst_mem_we", 32'(mem_we), 0);
        check_output("rst_mem_addr", 32'(mem_addr), 0);
        check_output("rst_mem_wdata", 32'(mem_wdata), 0);
        check_output("rst_lb_we", 32'(lb_we), 0);
        check_output("rst_lb_addr", 32'(lb_addr), 0);
        check_output("rst_lb_data", 32'(lb_data), 0);
        check_output("rst_underrun", 32'(underrun), 0);
        check_output("rst_host_ready", 32'(host_ready), 0);
        drive_cycle(0, 0, 0, 0, '0, '0);
        check_output("ready_after_rst", 32'(host_ready), 1);
        drive_cycle(0, 0, 0, 1, 19'h12345, 16'hF800);
        check_output("hw_we", 32'(mem_we), 1);
        check_output("hw_addr", 32'(mem_addr), 32'h12345);
        check_output("hw_data", 32'(mem_wdata), 32'hF800);
        apply_stimulus(0, 0, 0);

        foreach (vecs[v]) begin
            host_mode = vecs[v].host;
            run_fetch(vecs[v].fs, vecs[v].extra_at, base, bcnt, wr, und, fwe);
            check_output($sformatf("vec%0d_base", v), 32'(base), 32'(vecs[v].exp_base));
            check_output($sformatf("vec%0d_first_rd", v), 32'(fwe), 0);
            if (vecs[v].exp_busy >= 0)
                check_output($sformatf("vec%0d_busy", v), 32'(bcnt), 32'(vecs[v].exp_busy));
            if (vecs[v].exp_writes >= 0)
                check_output($sformatf("vec%0d_writes", v), 32'(wr), 32'(vecs[v].exp_writes));
            check_output($sformatf("vec%0d_underrun", v), 32'(und), 32'(vecs[v].exp_und));
            host_mode = 0;
            apply_stimulus(0, 0, 0);
        end

        // 480 back-to-back requests: one accepted, the rest rejected, pointer wraps.
        apply_stimulus(1, 0, 0);
        cnt = 0;
        for (int i = 0; i < V; i++) begin
            apply_stimulus(0, 1, 0);
            cnt += int'(underrun);
        end
        apply_stimulus(0, 0, 0);
        cnt += int'(underrun);
        check_output("wrap_underruns", 32'(cnt), 32'(V - 1));
        wait_idle(1000);
        run_fetch(0, -1, base, bcnt, wr, und, fwe);
        check_output("wrap_base", 32'(base), 0);

        // Reset with reads in flight.
        apply_stimulus(1, 1, 0);
        repeat (30) apply_stimulus(0, 0, 0);
        apply_stimulus(0, 0, 1);
        check_output("midrst_busy", 32'(busy), 0);
        check_output("midrst_mem_we", 32'(mem_we), 0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(0, 0, 0);
            cnt += int'(lb_we);
        end
        check_output("midrst_no_lb_we", 32'(cnt), 0);
        run_fetch(1, -1, base, bcnt, wr, und, fwe);
        check_output("midrst_refetch_base", 32'(base), 0);
        check_output("midrst_refetch_busy", 32'(bcnt), 643);

        host_mode = 2;
        for (int i = 0; i < 6000; i++)
            apply_stimulus(1'($urandom_range(0, 399) == 0), 1'($urandom_range(0, 149) == 0),
                           1'($urandom_range(0, 2999) == 0));
        host_mode = 0;
        repeat (4) apply_stimulus(0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        n_errors++;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
